vrf_wb_arbiter: RTL and testbench

//   Write-side front end of the 3-read-port vector register file. Arbitrates result

---
 rtl/vrf_wb_arbiter.sv | 77 +++++++
 tb/tb_vrf_wb_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vrf_wb_arbiter.sv
// VRF write-side front end: round-robin ALU/LSU writeback arbiter with a registered
// write port and a per-register pending scoreboard for WAW stalls.
module vrf_wb_arbiter #(
   parameter int unsigned VLEN     = 256,
   parameter int unsigned NUM_REGS = 32
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                alu_valid_i,
   output logic                alu_ready_o,
   input  logic [4:0]          alu_waddr_i,
   input  logic [VLEN-1:0]     alu_wdata_i,
   input  logic                lsu_valid_i,
   output logic                lsu_ready_o,
   input  logic [4:0]          lsu_waddr_i,
   input  logic [VLEN-1:0]     lsu_wdata_i,
   input  logic                issue_valid_i,
   input  logic [4:0]          issue_rd_i,
   output logic                issue_ready_o,
   output logic                vrf_we_o,
   output logic [4:0]          vrf_waddr_o,
   output logic [VLEN-1:0]     vrf_wdata_o,
   output logic [NUM_REGS-1:0] pending_o
);

   typedef enum logic {RR_ALU, RR_LSU} rr_e;

   rr_e                 rr_q, rr_d;
   logic                grant_alu, grant_lsu, accept;
   logic [4:0]          sel_waddr;
   logic [VLEN-1:0]     sel_wdata;
   logic [NUM_REGS-1:0] pending_q, pending_d;

   always_comb begin
      grant_alu = alu_valid_i && (!lsu_valid_i || (rr_q == RR_ALU));
      grant_lsu = lsu_valid_i && (!alu_valid_i || (rr_q == RR_LSU));
      accept    = grant_alu || grant_lsu;
      rr_d      = rr_q;
      if (grant_alu)      rr_d = RR_LSU;
      else if (grant_lsu) rr_d = RR_ALU;
      sel_waddr = grant_lsu ? lsu_waddr_i : alu_waddr_i;
      sel_wdata = grant_lsu ? lsu_wdata_i : alu_wdata_i;
   end

   assign alu_ready_o   = grant_alu;
   assign lsu_ready_o   = grant_lsu;
   assign issue_ready_o = !(issue_valid_i && pending_q[issue_rd_i]);
   assign pending_o     = pending_q;

   // Clear first, then set: a same-edge set/clear on one register leaves it pending.
   always_comb begin
      pending_d = pending_q;
      if (vrf_we_o) pending_d[vrf_waddr_o] = 1'b0;
      if (issue_valid_i && issue_ready_o && (issue_rd_i != '0))
         pending_d[issue_rd_i] = 1'b1;
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q        <= RR_ALU;
         pending_q   <= '0;
         vrf_we_o    <= 1'b0;
         vrf_waddr_o <= '0;
         vrf_wdata_o <= '0;
      end else begin
         rr_q      <= rr_d;
         pending_q <= pending_d;
         vrf_we_o  <= accept && (sel_waddr != '0);
         if (accept) begin
            vrf_waddr_o <= sel_waddr;
            vrf_wdata_o <= sel_wdata;
         end
      end
   end

endmodule

// File: tb/tb_vrf_wb_arbiter.sv
// Self-checking bench for vrf_wb_arbiter: directed vector table, hand sequences for
// contention / v0 / mid-op reset, and randomized traffic against a reference model.
module tb_vrf_wb_arbiter;
   localparam int VLEN = 256;
   localparam int NR   = 32;

   logic            clk = 1'b0;
   logic            rst_ni;
   logic            alu_valid_i, alu_ready_o, lsu_valid_i, lsu_ready_o;
   logic [4:0]      alu_waddr_i, lsu_waddr_i, issue_rd_i, vrf_waddr_o;
   logic [VLEN-1:0] alu_wdata_i, lsu_wdata_i, vrf_wdata_o;
   logic            issue_valid_i, issue_ready_o, vrf_we_o;
   logic [NR-1:0]   pending_o;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   vrf_wb_arbiter #(.VLEN(VLEN), .NUM_REGS(NR)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o),
      .alu_waddr_i(alu_waddr_i), .alu_wdata_i(alu_wdata_i),
      .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
      .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
      .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i),
      .issue_ready_o(issue_ready_o),
      .vrf_we_o(vrf_we_o), .vrf_waddr_o(vrf_waddr_o), .vrf_wdata_o(vrf_wdata_o),
      .pending_o(pending_o)
   );

   typedef struct {
      logic av; logic [4:0] aa; logic [31:0] ad;
      logic lv; logic [4:0] la; logic [31:0] ld;
      logic iv; logic [4:0] ir;
      logic e_ar; logic e_lr; logic e_ir; logic e_we;
      logic [4:0] e_wa; logic [31:0] e_wd; logic [31:0] e_pd;
   } vec_t;

   vec_t vec[21];

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic idle();
      alu_valid_i = 1'b0; alu_waddr_i = '0; alu_wdata_i = '0;
      lsu_valid_i = 1'b0; lsu_waddr_i = '0; lsu_wdata_i = '0;
      issue_valid_i = 1'b0; issue_rd_i = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic alu(input logic [4:0] a, input logic [31:0] d);
      alu_valid_i = 1'b1; alu_waddr_i = a; alu_wdata_i = {224'b0, d};
   endtask

   task automatic lsu(input logic [4:0] a, input logic [31:0] d);
      lsu_valid_i = 1'b1; lsu_waddr_i = a; lsu_wdata_i = {224'b0, d};
   endtask

   task automatic exp_wr(input string nm, input logic we, input logic [4:0] a, input logic [31:0] d);
      chk({nm, "_we"}, 256'(vrf_we_o), 256'(we));
      if (we) begin
         chk({nm, "_waddr"}, 256'(vrf_waddr_o), 256'(a));
         chk({nm, "_wdata"}, vrf_wdata_o, {224'b0, d});
      end
   endtask

   task automatic do_reset();
      idle();
      rst_ni = 1'b0;
      @(negedge clk);
      chk("rst_we", 256'(vrf_we_o), 256'(1'b0));
      chk("rst_pending", 256'(pending_o), 256'(0));
      chk("rst_alu_ready", 256'(alu_ready_o), 256'(1'b0));
      chk("rst_lsu_ready", 256'(lsu_ready_o), 256'(1'b0));
      chk("rst_wdata", vrf_wdata_o, 256'(0));
      tick();
      tick();
      rst_ni = 1'b1;
   endtask

   function automatic logic [255:0] r256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // reference model state
   logic         m_turn_lsu;
   logic [31:0]  m_pend;
   logic         m_we;
   logic [4:0]   m_waddr;
   logic [255:0] m_wdata;

   initial begin
      vec[0]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,  1'b0,5'd0, 1'b0,1'b0,1'b1,1'b0,5'd0,32'h0,        32'h0};
      vec[1]  = '{1'b1,5'd5,32'hA5A5A5A5, 1'b0,5'd0,32'h0,  1'b0,5'd0, 1'b1,1'b0,1'b1,1'b0,5'd0,32'h0,        32'h0};
      vec[2]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,  1'b0,5'd0, 1'b0,1'b0,1'b1,1'b1,5'd5,32'hA5A5A5A5, 32'h0};
      vec[3]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,  1'b0,5'd0, 1'b0,1'b0,1'b1,1'b0,5'd0,32'h0,        32'h0};
      vec[4]  = '{1'b1,5'd1,32'h11,       1'b1,5'd2,32'h22, 1'b0,5'd0, 1'b0,1'b1,1'b1,1'b0,5'd0,32'h0,        32'h0};
      vec[5]  = '{1'b1,5'd1,32'h11,       1'b1,5'd3,32'h33, 1'b0,5'd0, 1'b1,1'b0,1'b1,1'b1,5'd2,32'h22,       32'h0};
      vec[6]  = '{1'b1,5'd4,32'h44,       1'b1,5'd3,32'h33, 1'b0,5'd0, 1'b0,1'b1,1'b1,1'b1,5'd1,32'h11,       32'h0};
      vec[7]  = '{1'b1,5'd4,32'h44,       1'b0,5'd0,32'h0,  1'b0,5'd0, 1'b1,1'b0,1'b1,1'b1,5'd3,32'h33,       32'h0};
      vec[8]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,  1'b0,5'd0, 1'b0,1'b0,1'b1,1'b1,5'd4,32'h44,       32'h0};
      vec[9]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,  1'b1,5'd7, 1'b0,1'b0,1'b1,1'b0,5'd0,32'h0,        32'h0};
      vec[10] = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,  1'b1,5'd7, 1'b0,1'b0,1'b0,1'b0,5'd0,32'h0,        32'h80};
      vec[11] = '{1'b0,5'd0,32'h0,        1'b1,5'd7,32'h77, 1'b0,5'd0, 1'b0,1'b1,1'b1,1'b0,5'd0,32'h0,        32'h80};
      vec[12] = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,  1'b0,5'd0, 1'b0,1'b0,1'b1,1'b1,5'd7,32'h77,       32'h80};
      vec[13] = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,  1'b0,5'd0, 1'b0,1'b0,1'b1,1'b0,5'd0,32'h0,        32'h0};
      vec[14] = '{1'b1,5'd0,32'h99,       1'b0,5'd0,32'h0,  1'b1,5'd0, 1'b1,1'b0,1'b1,1'b0,5'd0,32'h0,        32'h0};
      vec[15] = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,  1'b0,5'd0, 1'b0,1'b0,1'b1,1'b0,5'd0,32'h0,        32'h0};
      vec[16] = '{1'b1,5'd3,32'h33,       1'b0,5'd0,32'h0,  1'b0,5'd0, 1'b1,1'b0,1'b1,1'b0,5'd0,32'h0,        32'h0};
      vec[17] = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,  1'b1,5'd3, 1'b0,1'b0,1'b1,1'b1,5'd3,32'h33,       32'h0};
      vec[18] = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,  1'b0,5'd0, 1'b0,1'b0,1'b1,1'b0,5'd0,32'h0,        32'h8};
      vec[19] = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,  1'b1,5'd3, 1'b0,1'b0,1'b0,1'b0,5'd0,32'h0,        32'h8};
      vec[20] = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,  1'b0,5'd3, 1'b0,1'b0,1'b1,1'b0,5'd0,32'h0,        32'h8};

      // directed vector table
      do_reset();
      for (int i = 0; i < 21; i++) begin
         idle();
         if (vec[i].av) alu(vec[i].aa, vec[i].ad);
         if (vec[i].lv) lsu(vec[i].la, vec[i].ld);
         issue_valid_i = vec[i].iv;
         issue_rd_i    = vec[i].ir;
         @(negedge clk);
         chk($sformatf("vec%0d_alu_ready", i), 256'(alu_ready_o), 256'(vec[i].e_ar));
         chk($sformatf("vec%0d_lsu_ready", i), 256'(lsu_ready_o), 256'(vec[i].e_lr));
         chk($sformatf("vec%0d_issue_ready", i), 256'(issue_ready_o), 256'(vec[i].e_ir));
         chk($sformatf("vec%0d_pending", i), 256'(pending_o), 256'(vec[i].e_pd));
         exp_wr($sformatf("vec%0d", i), vec[i].e_we, vec[i].e_wa, vec[i].e_wd);
         tick();
      end

      // contention from reset: ALU, LSU, ALU, LSU on consecutive cycles
      do_reset();
      alu(5'd10, 32'hA0); lsu(5'd20, 32'hB0);
      @(negedge clk);
      chk("cont0_alu_ready", 256'(alu_ready_o), 256'(1'b1));
      chk("cont0_lsu_ready", 256'(lsu_ready_o), 256'(1'b0));
      tick();
      alu(5'd11, 32'hA1);
      @(negedge clk);
      chk("cont1_lsu_ready", 256'(lsu_ready_o), 256'(1'b1));
      exp_wr("cont1", 1'b1, 5'd10, 32'hA0);
      tick();
      lsu(5'd21, 32'hB1);
      @(negedge clk);
      chk("cont2_alu_ready", 256'(alu_ready_o), 256'(1'b1));
      exp_wr("cont2", 1'b1, 5'd20, 32'hB0);
      tick();
      alu(5'd12, 32'hA2);
      @(negedge clk);
      chk("cont3_lsu_ready", 256'(lsu_ready_o), 256'(1'b1));
      exp_wr("cont3", 1'b1, 5'd11, 32'hA1);
      tick();
      idle();
      @(negedge clk);
      exp_wr("cont4", 1'b1, 5'd21, 32'hB1);
      tick();
      @(negedge clk);
      exp_wr("cont5", 1'b0, 5'd0, 32'h0);

      // v0 write dropped, then reset between accept and output cycle
      do_reset();
      alu(5'd0, 32'h55);
      @(negedge clk);
      chk("v0_alu_ready", 256'(alu_ready_o), 256'(1'b1));
      tick();
      idle();
      @(negedge clk);
      exp_wr("v0_out", 1'b0, 5'd0, 32'h0);
      tick();
      alu(5'd9, 32'h99);
      issue_valid_i = 1'b1; issue_rd_i = 5'd9;
      @(negedge clk);
      chk("midrst_alu_ready", 256'(alu_ready_o), 256'(1'b1));
      chk("midrst_issue_ready", 256'(issue_ready_o), 256'(1'b1));
      tick();
      idle();
      rst_ni = 1'b0;
      @(negedge clk);
      exp_wr("midrst_during", 1'b0, 5'd0, 32'h0);
      chk("midrst_pending", 256'(pending_o), 256'(0));
      tick();
      rst_ni = 1'b1;
      @(negedge clk);
      exp_wr("midrst_after", 1'b0, 5'd0, 32'h0);
      chk("midrst_pending_after", 256'(pending_o), 256'(0));

      // randomized traffic against the reference model
      do_reset();
      m_turn_lsu = 1'b0; m_pend = '0; m_we = 1'b0; m_waddr = '0; m_wdata = '0;
      begin
         logic         a_req, l_req, iv, ea, el, ei;
         logic [4:0]   a_addr, l_addr, rd, w_addr;
         logic [255:0] a_data, l_data;
         logic [31:0]  np;
         a_req = 1'b0; l_req = 1'b0;
         a_addr = '0; l_addr = '0; a_data = '0; l_data = '0;
         for (int c = 0; c < 2000; c++) begin
            if (!a_req && ($urandom_range(0, 2) != 0)) begin
               a_req = 1'b1; a_addr = 5'($urandom_range(0, 7)); a_data = r256();
            end
            if (!l_req && ($urandom_range(0, 2) != 0)) begin
               l_req = 1'b1; l_addr = 5'($urandom_range(0, 7)); l_data = r256();
            end
            iv = 1'($urandom_range(0, 1));
            rd = 5'($urandom_range(0, 7));
            alu_valid_i = a_req; alu_waddr_i = a_addr; alu_wdata_i = a_data;
            lsu_valid_i = l_req; lsu_waddr_i = l_addr; lsu_wdata_i = l_data;
            issue_valid_i = iv; issue_rd_i = rd;
            @(negedge clk);
            ea = a_req && (!l_req || !m_turn_lsu);
            el = l_req && (!a_req || m_turn_lsu);
            ei = !(iv && m_pend[rd]);
            chk("rnd_alu_ready", 256'(alu_ready_o), 256'(ea));
            chk("rnd_lsu_ready", 256'(lsu_ready_o), 256'(el));
            chk("rnd_issue_ready", 256'(issue_ready_o), 256'(ei));
            chk("rnd_we", 256'(vrf_we_o), 256'(m_we));
            chk("rnd_waddr", 256'(vrf_waddr_o), 256'(m_waddr));
            chk("rnd_wdata", vrf_wdata_o, m_wdata);
            chk("rnd_pending", 256'(pending_o), 256'(m_pend));
            np = m_pend;
            if (m_we) np[m_waddr] = 1'b0;
            if (iv && ei && (rd != 5'd0)) np[rd] = 1'b1;
            if (ea || el) begin
               w_addr     = ea ? a_addr : l_addr;
               m_wdata    = ea ? a_data : l_data;
               m_waddr    = w_addr;
               m_we       = (w_addr != 5'd0);
               m_turn_lsu = ea;
            end else begin
               m_we = 1'b0;
            end
            if (ea) a_req = 1'b0;
            if (el) l_req = 1'b0;
            m_pend = np;
            tick();
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
